// File: rtl/ifm_mem_pkg.sv
// Shared geometry and sequencer state encoding for the 16-bank input-feature-map BRAM.
package ifm_mem_pkg;

  localparam int NUM_BANKS = 16;
  localparam int DEPTH     = 128;
  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 128;
  localparam int BANK_W    = $clog2(NUM_BANKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ifm_skid_fifo.sv
// Small synchronous FIFO with occupancy count; absorbs BRAM read latency and stream backpressure.
module ifm_skid_fifo #(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 4,
  localparam int CNT_W  = $clog2(ENTRIES + 1),
  localparam int PTR_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [ENTRIES];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && count == CNT_W'(ENTRIES)))
        else $error("ifm_skid_fifo: overflow");
      assert (!(pop && empty))
        else $error("ifm_skid_fifo: underflow");
    end
  end

endmodule

// File: rtl/ifm_bank_reader.sv
// Port-B read sequencer: walks all banks bank-major and streams words over valid/ready.
// Optional macro IFM_RD_CHECKSUM_EN adds oChecksum (wrapping sum of 32-bit lanes of handshaked words).
module ifm_bank_reader
  import ifm_mem_pkg::*;
#(
  parameter int NUM_BANKS  = ifm_mem_pkg::NUM_BANKS,
  parameter int DEPTH      = ifm_mem_pkg::DEPTH,
  parameter int ADDR_W     = ifm_mem_pkg::ADDR_W,
  parameter int DATA_W     = ifm_mem_pkg::DATA_W,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        iStart,
  output logic                        oBusy,
  output logic                        oDone,
  output logic [NUM_BANKS-1:0]        o_enb,
  output logic [ADDR_W-1:0]           o_addrb,
  input  logic [NUM_BANKS*DATA_W-1:0] i_dob,
  output logic [DATA_W-1:0]           o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [BANK_W-1:0]           o_bank,
  output logic [ADDR_W-1:0]           o_addr,
`ifdef IFM_RD_CHECKSUM_EN
  output logic [31:0]                 oChecksum,
`endif
  output logic                        o_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = DATA_W + BANK_W + ADDR_W;
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e state, state_n;

  logic [BANK_W-1:0] bank_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] addrb_q;
  logic              start_ok, issue, last_issue, credit_ok, drain_ok;
  logic              push, pop, empty;

  logic [RD_LAT-1:0] pipe_v;
  logic [BANK_W-1:0] pipe_bank [RD_LAT];
  logic [ADDR_W-1:0] pipe_addr [RD_LAT];
  logic [CNT_W-1:0]  in_flight;
  logic [CNT_W-1:0]  fifo_count;

  logic [ENT_W-1:0]  push_data, head;
  logic [DATA_W-1:0] head_data;
  logic [BANK_W-1:0] head_bank;
  logic [ADDR_W-1:0] head_addr;

  always_comb begin
    in_flight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) in_flight = in_flight + CNT_W'(pipe_v[i]);
  end

  // Credit: every issued read already owns a FIFO slot, so the FIFO can never overflow.
  assign credit_ok  = ({1'b0, in_flight} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign start_ok   = (state == IDLE) && iStart;
  assign issue      = (state == RUN) && credit_ok;
  assign last_issue = issue && (bank_cnt == LAST_BANK) && (addr_cnt == LAST_ADDR);
  assign pop        = o_valid && i_ready;
  assign drain_ok   = (in_flight == '0) && (empty || (fifo_count == CNT_W'(1) && pop));

  always_comb begin
    state_n = state;
    oBusy   = 1'b0;
    oDone   = 1'b0;
    case (state)
      IDLE:    if (iStart) state_n = RUN;
      RUN: begin
        oBusy = 1'b1;
        if (last_issue) state_n = DRAIN;
      end
      DRAIN: begin
        oBusy = 1'b1;
        if (drain_ok) state_n = DONE;
      end
      DONE: begin
        oDone   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_cnt <= '0;
      addr_cnt <= '0;
      addrb_q  <= '0;
    end else if (start_ok) begin
      bank_cnt <= '0;
      addr_cnt <= '0;
    end else if (issue) begin
      addrb_q <= addr_cnt;
      if (addr_cnt == LAST_ADDR) begin
        addr_cnt <= '0;
        bank_cnt <= bank_cnt + BANK_W'(1);
      end else begin
        addr_cnt <= addr_cnt + ADDR_W'(1);
      end
    end
  end

  assign o_enb   = issue ? (NUM_BANKS'(1) << bank_cnt) : '0;
  assign o_addrb = issue ? addr_cnt : addrb_q;

  // Tags travel alongside the BRAM latency; only the valid bits need clearing on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= issue;
      for (int unsigned i = 1; i < RD_LAT; i++) pipe_v[i] <= pipe_v[i-1];
    end
    pipe_bank[0] <= bank_cnt;
    pipe_addr[0] <= addr_cnt;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pipe_bank[i] <= pipe_bank[i-1];
      pipe_addr[i] <= pipe_addr[i-1];
    end
  end

  assign push      = pipe_v[RD_LAT-1];
  assign push_data = {i_dob[int'(pipe_bank[RD_LAT-1]) * DATA_W +: DATA_W],
                      pipe_bank[RD_LAT-1], pipe_addr[RD_LAT-1]};

  ifm_skid_fifo #(
    .WIDTH   (ENT_W),
    .ENTRIES (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign {head_data, head_bank, head_addr} = head;
  assign o_valid = !empty;
  assign o_data  = o_valid ? head_data : '0;
  assign o_bank  = o_valid ? head_bank : '0;
  assign o_addr  = o_valid ? head_addr : '0;
  assign o_last  = o_valid && (head_bank == LAST_BANK) && (head_addr == LAST_ADDR);

`ifdef IFM_RD_CHECKSUM_EN
  logic [31:0] lane_sum;

  always_comb begin
    lane_sum = '0;
    for (int unsigned l = 0; l < DATA_W / 32; l++) lane_sum = lane_sum + o_data[l*32 +: 32];
  end

  always_ff @(posedge clk) begin
    if (rst || start_ok) oChecksum <= '0;
    else if (pop)        oChecksum <= oChecksum + lane_sum;
  end
`endif

endmodule

// File: tb/tb_ifm_bank_reader.sv
// Self-checking bench for ifm_bank_reader: behavioural BRAM, stream model and per-cycle compare.
module tb_ifm_bank_reader;

  localparam int NB      = 16;
  localparam int DP      = 128;
  localparam int AW      = 9;
  localparam int DW      = 128;
  localparam int TOTAL   = NB * DP;
  localparam int CREDITS = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           iStart = 1'b0;
  logic           i_ready = 1'b0;
  logic           oBusy, oDone, o_valid, o_last;
  logic [NB-1:0]  o_enb;
  logic [AW-1:0]  o_addrb, o_addr;
  logic [NB*DW-1:0] i_dob;
  logic [DW-1:0]  o_data;
  logic [3:0]     o_bank;
`ifdef IFM_RD_CHECKSUM_EN
  logic [31:0]    oChecksum;
`endif

  ifm_bank_reader dut (
    .clk       (clk),
    .rst       (rst),
    .iStart    (iStart),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .o_enb     (o_enb),
    .o_addrb   (o_addrb),
    .i_dob     (i_dob),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_bank    (o_bank),
    .o_addr    (o_addr),
`ifdef IFM_RD_CHECKSUM_EN
    .oChecksum (oChecksum),
`endif
    .o_last    (o_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic ones_mode = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory contents: bank/addr tag in the top bits, a mixed value in the low lane.
  function automatic logic [DW-1:0] word_fn(input int b, input int a);
    if (ones_mode) return {4{32'h0000_0001}};
    return {b[7:0], a[8:0], 79'd0, 32'(b * 4099 + a * 37 + 5)};
  endfunction

  function automatic logic [31:0] lanes(input logic [DW-1:0] d);
    return d[31:0] + d[63:32] + d[95:64] + d[127:96];
  endfunction

  // Behavioural BRAM with two-cycle read latency; disabled banks return junk.
  logic [NB-1:0] en1 = '0, en2 = '0;
  logic [AW-1:0] a1 = '0, a2 = '0;
  always @(posedge clk) begin
    en1 <= o_enb;
    a1  <= o_addrb;
    en2 <= en1;
    a2  <= a1;
  end
  always_comb begin
    i_dob = '0;
    for (int b = 0; b < NB; b++)
      i_dob[b*DW +: DW] = en2[b] ? word_fn(b, int'(a2)) : ~word_fn(b, int'(a2));
  end

  // Stream model: issued reads and accepted words, each as a linear index into bank-major order.
  int issued = 0, hs_total = 0, done_cnt = 0, last_cnt = 0;
  int run_id = 0, seen_run = 0;
  int eb, ea;
  logic [31:0]   model_sum = '0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst || run_id != seen_run) begin
      seen_run   = run_id;
      issued     = 0;
      hs_total   = 0;
      done_cnt   = 0;
      last_cnt   = 0;
      model_sum  = '0;
      prev_stall = 1'b0;
    end
    if (!rst) begin
      if (o_enb != '0) begin
        chk("issue_in_range", issued < TOTAL, 1'b1);
        chk("issue_enb", o_enb, NB'(1) << (issued / DP));
        chk("issue_addrb", o_addrb, issued % DP);
        issued++;
        chk("credit_limit", (issued - hs_total) <= CREDITS, 1'b1);
      end
      if (prev_stall) begin
        chk("stall_valid_hold", o_valid, 1'b1);
        chk("stall_data_hold", o_data, prev_data);
      end
      if (o_valid) begin
        chk("no_extra_word", hs_total < TOTAL, 1'b1);
        eb = hs_total / DP;
        ea = hs_total % DP;
        chk("out_bank", o_bank, eb);
        chk("out_addr", o_addr, ea);
        chk("out_data", o_data, word_fn(eb, ea));
        chk("out_last", o_last, hs_total == TOTAL - 1);
        if (i_ready) begin
          model_sum = model_sum + lanes(word_fn(eb, ea));
          if (o_last) last_cnt++;
          hs_total++;
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      if (oDone) begin
        done_cnt++;
        chk("done_after_last_word", hs_total, TOTAL);
`ifdef IFM_RD_CHECKSUM_EN
        chk("checksum_at_done", oChecksum, model_sum);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    run_id++;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic finish_run(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", done_cnt, 1);
    repeat (3) tick();
    chk("single_done", done_cnt, 1);
    chk("idle_after_done", oBusy, 1'b0);
    chk("words_total", hs_total, TOTAL);
    chk("reads_total", issued, TOTAL);
    chk("last_once", last_cnt, 1);
`ifdef IFM_RD_CHECKSUM_EN
    chk("checksum_held", oChecksum, model_sum);
`endif
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_enb", o_enb, '0);
    chk("rst_addrb", o_addrb, '0);
    chk("rst_busy", oBusy, 1'b0);
    chk("rst_done", oDone, 1'b0);
    chk("rst_data", o_data, '0);
    chk("rst_bank", o_bank, '0);
    chk("rst_addr", o_addr, '0);
    chk("rst_last", o_last, 1'b0);
    rst = 1'b0;
    tick();

    // Full run, always ready: latency 3, then one word per cycle.
    i_ready = 1'b1;
    start_run();
    chk("busy_after_start", oBusy, 1'b1);
    n = 0;
    while (!o_valid && n < 10) begin
      tick();
      n++;
    end
    chk("first_valid_latency", n, 3);
    n = 0;
    while (hs_total < TOTAL && n < 4000) begin
      tick();
      n++;
    end
    chk("back_to_back_cycles", n, TOTAL);
    finish_run(50);

    // Toggling then random ready, with ignored start pulses while busy.
    start_run();
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      i_ready = (n < 40) ? (n % 2 == 0) : ($urandom_range(0, 3) != 0);
      iStart  = (hs_total < 2000) && ($urandom_range(0, 49) == 0);
      tick();
      n++;
    end
    iStart  = 1'b0;
    i_ready = 1'b1;
    finish_run(50);

    // Downstream stalled from the start: only the credit budget is issued.
    i_ready = 1'b0;
    start_run();
    repeat (19) tick();
    chk("stall_reads_issued", issued, CREDITS);
    chk("stall_enb_idle", o_enb, '0);
    chk("stall_valid", o_valid, 1'b1);
    i_ready = 1'b1;
    finish_run(3000);

    // Reset in the middle of a transfer, then a clean restart.
    start_run();
    n = 0;
    while (hs_total < 700 && n < 5000) begin
      i_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    chk("reached_word_700", hs_total, 700);
    rst = 1'b1;
    tick();
    chk("midrst_valid", o_valid, 1'b0);
    chk("midrst_enb", o_enb, '0);
    chk("midrst_busy", oBusy, 1'b0);
    chk("midrst_done", oDone, 1'b0);
    rst = 1'b0;
    repeat (6) tick();
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_no_issue", issued, 0);
    i_ready = 1'b1;
    start_run();
    finish_run(3000);

`ifdef IFM_RD_CHECKSUM_EN
    ones_mode = 1'b1;
    start_run();
    finish_run(3000);
    chk("checksum_all_ones", oChecksum, 32'h0000_2000);
    ones_mode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifm_bank_reader.md
Name: ifm_bank_reader

Overview:
- Read-side sequencer for the 16-bank input-feature-map BRAM (128 words x 128 bits per bank, 9-bit address).
- The existing loader fills this memory through port A. This block drives port B: it walks every bank in bank-major order and streams the words out over a valid/ready interface to the conv datapath (layer00 input path).
- It absorbs the BRAM read latency and downstream backpressure with a small credit-controlled skid FIFO.

Parameters:
- NUM_BANKS, 16, number of BRAM banks.
- DEPTH, 128, words read per bank.
- ADDR_W, 9, BRAM address width.
- DATA_W, 128, BRAM word width.
- RD_LAT, 2, BRAM port-B read latency in cycles (enb/addrb to dob valid).
- FIFO_DEPTH, 4, skid FIFO entries; must be >= RD_LAT+1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- iStart  in  1  start pulse; sampled only in IDLE.
- oBusy  out  1  high from the accepted start until done.
- oDone  out  1  one-cycle pulse after the final word handshake.
- o_enb  out  NUM_BANKS  one-hot port-B enable.
- o_addrb  out  ADDR_W  port-B read address.
- i_dob  in  NUM_BANKS*DATA_W  concatenated port-B read data; bank b occupies bits [b*DATA_W +: DATA_W].
- o_data  out  DATA_W  stream data.
- o_valid  out  1  stream valid.
- i_ready  in  1  stream ready.
- o_bank  out  4  bank index of o_data.
- o_addr  out  ADDR_W  word address of o_data.
- o_last  out  1  high on word (NUM_BANKS-1, DEPTH-1).

Behaviour:
- Reset values: all outputs 0. FIFO empty, counters 0, latency pipeline cleared, FSM in IDLE.
- FSM states:
  - IDLE -> RUN on iStart.
  - RUN -> DRAIN after the last read is issued.
  - DRAIN -> DONE when the FIFO is empty, no reads are in flight, and the last handshake has completed.
  - DONE -> IDLE unconditionally; oDone=1 for exactly this cycle.
- Issue order: bank 0 addr 0..DEPTH-1, then bank 1, and so on up to bank NUM_BANKS-1. 2048 reads total at default parameters.
- Issue rule: in RUN, issue one read per cycle (o_enb one-hot, o_addrb=addr) when (in_flight + fifo_count) < FIFO_DEPTH. Otherwise o_enb=0. o_addrb holds its value when not issuing.
- Addressing: the addr counter wraps DEPTH-1 -> 0 and increments bank; the last bank's wrap ends issue.
- Latency pipeline: a RD_LAT-deep shift of {valid, bank, addr}. On exit, write i_dob[bank slice] plus tags into the FIFO. in_flight equals the popcount of the pipeline valids.
- Output: o_valid = FIFO not empty; the head drives o_data, o_bank, o_addr and o_last. Pop on o_valid & i_ready.
- Data stability: o_data and tags stay stable while o_valid=1 and i_ready=0.
- Latency: first o_valid appears RD_LAT+1 cycles after iStart is accepted. With i_ready held at 1, throughput is 1 word/cycle.
- Simultaneous FIFO push and pop: count unchanged, both take effect. FIFO never overflows by construction of the credit rule. Overflow is an assertion failure.
- iStart in any state other than IDLE is ignored.
- rst mid-operation: return to IDLE within one cycle. o_enb=0, o_valid=0 immediately, in-flight data discarded, no oDone.

Optional Feature:
- Macro: IFM_RD_CHECKSUM_EN.
- When defined:
  - Adds output oChecksum[31:0]. It is the wrapping 32-bit sum of the four 32-bit lanes of every handshaked word.
  - Cleared when iStart is accepted; final value is valid in the oDone cycle and held until the next start.
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ifm_mem_pkg holds:
  - constants NUM_BANKS, DEPTH, ADDR_W, DATA_W;
  - bank-index width localparam;
  - FSM state encoding (IDLE, RUN, DRAIN, DONE).
- One sub-module, ifm_skid_fifo: synchronous FIFO with FIFO_DEPTH entries, count output and an overflow assertion.

Test Plan:
- Model: a behavioural BRAM returns {bank[7:0], addr[8:0], zero-pad} after RD_LAT.
- Reset then iStart with i_ready=1 -> 2048 words in order. First o_valid occurs at cycle 3 after start. Words 0..2047 arrive back-to-back, o_last only on bank 15 addr 127, and a single oDone pulse follows the last handshake.
- i_ready toggling 1,0,1,0 -> no word dropped or duplicated. o_data is stable during stalls, and in_flight+fifo_count never exceeds 4.
- i_ready=0 for 20 cycles after start -> exactly 4 reads issued, then o_enb=0 until ready returns.
- rst asserted at word 700 -> next cycle o_valid=0, o_enb=0, oBusy=0 and no oDone. A following iStart restarts at bank 0 addr 0.
- iStart pulsed while busy -> ignored; total word count stays 2048.
- With IFM_RD_CHECKSUM_EN defined and all words equal to 0x00000001_00000001_00000001_00000001 -> oChecksum=0x00002000 at oDone.
